// File: rtl/clocked_ops_pkg.sv
// Shared definitions for the clocked-operations go/finished interface.
// Used by the dispatcher (initiator) and by any responder on the same interface.
package clocked_ops_pkg;

  localparam int unsigned OP_ID_W = 8;

  // Dispatcher FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Operation selectors understood by the responder
  localparam logic [OP_ID_W-1:0] OP_GCD  = 8'd0;
  localparam logic [OP_ID_W-1:0] OP_FACT = 8'd1;

endpackage

// File: rtl/clocked_op_req_fifo.sv
// Request FIFO for the dispatcher.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, wr_data       write request (ignored when full)
//   pop                 read request (ignored when empty)
//   rd_data_c           head entry, combinational read
//   not_full, empty     registered status flags
//   count_nxt_c         occupancy after this cycle's push/pop
module clocked_op_req_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         wr_data,
  input  logic                     pop,
  output logic [width-1:0]         rd_data_c,
  output logic                     not_full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count_nxt_c
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok     = push && not_full;
  assign pop_ok      = pop && !empty;
  assign count_nxt_c = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign rd_data_c   = mem[rd_ptr];

  // Pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt_c;
      not_full <= (count_nxt_c != CNT_W'(depth));
      empty    <= (count_nxt_c == '0);
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/clocked_op_dispatcher.sv
// Initiator for the clocked-operations go/finished interface.
// Queues requests, launches one operation at a time, waits for a finished
// rising edge (or a timeout) and returns the result on a valid/ready port.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_ready/req_*        request input (operation id + 3 operands)
//   go/operation_id/input_var_*      launch side towards the responder
//   results/finished                 completion side from the responder
//   rsp_valid/rsp_ready/rsp_*        response output
//   busy                             op in flight or requests queued
module clocked_op_dispatcher
  import clocked_ops_pkg::*;
#(
  parameter int unsigned register_width = 32,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_operation_id,
  input  logic [register_width-1:0] req_input_var_0,
  input  logic [register_width-1:0] req_input_var_1,
  input  logic [register_width-1:0] req_input_var_2,
  output logic                      go,
  output logic [7:0]                operation_id,
  output logic [register_width-1:0] input_var_0,
  output logic [register_width-1:0] input_var_1,
  output logic [register_width-1:0] input_var_2,
  input  logic [register_width-1:0] results,
  input  logic                      finished,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_operation_id,
  output logic [register_width-1:0] rsp_results,
  output logic                      rsp_timeout,
  output logic                      busy
);

  localparam int unsigned RW        = register_width;
  localparam int unsigned PAYLOAD_W = OP_ID_W + 3 * RW;
  localparam int unsigned CNT_W     = $clog2(fifo_depth) + 1;
  localparam int unsigned TMO_W     = $clog2(timeout_cycles);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

  state_t               state, state_next;
  logic                 finished_q;
  logic                 fin_rise;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 go_d;
  logic [OP_ID_W-1:0]   op_id_d;
  logic [RW-1:0]        var0_d, var1_d, var2_d;
  logic                 rsp_valid_d;
  logic [OP_ID_W-1:0]   rsp_id_d;
  logic [RW-1:0]        rsp_res_d;
  logic                 rsp_to_d;
  logic                 busy_d;

  logic                 pop_c;
  logic                 fifo_not_full;
  logic                 fifo_empty;
  logic [PAYLOAD_W-1:0] fifo_head_c;
  logic [CNT_W-1:0]     fifo_count_nxt_c;

  assign req_ready = fifo_not_full;
  assign fin_rise  = finished && !finished_q;

  clocked_op_req_fifo #(
    .width (PAYLOAD_W),
    .depth (fifo_depth)
  ) u_req_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (req_valid && fifo_not_full),
    .wr_data     ({req_operation_id, req_input_var_2, req_input_var_1, req_input_var_0}),
    .pop         (pop_c),
    .rd_data_c   (fifo_head_c),
    .not_full    (fifo_not_full),
    .empty       (fifo_empty),
    .count_nxt_c (fifo_count_nxt_c)
  );

  // Next-state and next-register values; everything holds by default
  always_comb begin
    state_next  = state;
    pop_c       = 1'b0;
    go_d        = 1'b0;
    tmo_d       = tmo_q;
    op_id_d     = operation_id;
    var0_d      = input_var_0;
    var1_d      = input_var_1;
    var2_d      = input_var_2;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_operation_id;
    rsp_res_d   = rsp_results;
    rsp_to_d    = rsp_timeout;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          {op_id_d, var2_d, var1_d, var0_d} = fifo_head_c;
          go_d       = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d      = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A completion edge takes priority over a coincident timeout
        if (fin_rise) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = operation_id;
          rsp_res_d   = results;
          rsp_to_d    = 1'b0;
          state_next  = RESPOND;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = operation_id;
          rsp_res_d   = '0;
          rsp_to_d    = 1'b1;
          state_next  = RESPOND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_d = (state_next != IDLE) || (fifo_count_nxt_c != '0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      finished_q       <= 1'b0;
      tmo_q            <= '0;
      go               <= 1'b0;
      operation_id     <= '0;
      input_var_0      <= '0;
      input_var_1      <= '0;
      input_var_2      <= '0;
      rsp_valid        <= 1'b0;
      rsp_operation_id <= '0;
      rsp_results      <= '0;
      rsp_timeout      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_next;
      finished_q       <= finished;
      tmo_q            <= tmo_d;
      go               <= go_d;
      operation_id     <= op_id_d;
      input_var_0      <= var0_d;
      input_var_1      <= var1_d;
      input_var_2      <= var2_d;
      rsp_valid        <= rsp_valid_d;
      rsp_operation_id <= rsp_id_d;
      rsp_results      <= rsp_res_d;
      rsp_timeout      <= rsp_to_d;
      busy             <= busy_d;
    end
  end

endmodule

// File: tb/tb_clocked_op_dispatcher.sv
// Directed bench for clocked_op_dispatcher with a behavioural responder.
module tb_clocked_op_dispatcher;
  import clocked_ops_pkg::*;

  localparam int unsigned RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_operation_id = '0;
  logic [RW-1:0] req_input_var_0 = '0;
  logic [RW-1:0] req_input_var_1 = '0;
  logic [RW-1:0] req_input_var_2 = '0;
  logic          go;
  logic [7:0]    operation_id;
  logic [RW-1:0] input_var_0, input_var_1, input_var_2;
  logic [RW-1:0] results;
  logic          finished;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_operation_id;
  logic [RW-1:0] rsp_results;
  logic          rsp_timeout;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int go_cnt   = 0;

  // Responder: automatic (finished resp_delay cycles after go, results = op0*32) or manual
  bit            use_auto = 1'b1;
  logic          man_fin = 1'b0;
  logic [RW-1:0] man_res = '0;
  logic          auto_fin = 1'b0;
  logic [RW-1:0] auto_res = '0;
  logic [RW-1:0] lat_op0 = '0;
  int unsigned   resp_delay = 10;
  int unsigned   resp_cnt = 0;
  bit            resp_pend = 1'b0;

  assign finished = use_auto ? auto_fin : man_fin;
  assign results  = use_auto ? auto_res : man_res;

  clocked_op_dispatcher #(
    .register_width (RW),
    .fifo_depth     (4),
    .timeout_cycles (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_operation_id (req_operation_id),
    .req_input_var_0  (req_input_var_0),
    .req_input_var_1  (req_input_var_1),
    .req_input_var_2  (req_input_var_2),
    .go               (go),
    .operation_id     (operation_id),
    .input_var_0      (input_var_0),
    .input_var_1      (input_var_1),
    .input_var_2      (input_var_2),
    .results          (results),
    .finished         (finished),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_operation_id (rsp_operation_id),
    .rsp_results      (rsp_results),
    .rsp_timeout      (rsp_timeout),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (go) go_cnt <= go_cnt + 1;
  end

  always @(posedge clk) begin
    if (go) begin
      auto_fin  <= 1'b0;
      lat_op0   <= input_var_0;
      resp_cnt  <= resp_delay - 1;
      resp_pend <= 1'b1;
    end else if (resp_pend) begin
      if (resp_cnt == 1) begin
        auto_fin  <= 1'b1;
        auto_res  <= lat_op0 << 5;
        resp_pend <= 1'b0;
      end else begin
        resp_cnt <= resp_cnt - 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input string tag, input logic [7:0] id, input logic [RW-1:0] a0);
    int n = 0;
    @(negedge clk);
    req_valid        = 1'b1;
    req_operation_id = id;
    req_input_var_0  = a0;
    req_input_var_1  = a0 + 32'd1;
    req_input_var_2  = a0 + 32'd2;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(req_ready), 32'd1);
  endtask

  task automatic end_push();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] id, input logic [RW-1:0] res,
                            input logic to);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_operation_id), 32'(id));
    check({tag, "_res"}, rsp_results, res);
    check({tag, "_to"}, 32'(rsp_timeout), 32'(to));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int g0;
    int n;
    bit bad;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_go", 32'(go), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_opid", 32'(operation_id), 32'd0);
    reset = 1'b0;

    // 1: single op, finished 10 cycles after go, results 96
    g0 = go_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_operation_id = OP_FACT; req_input_var_0 = 32'd3;
    req_input_var_1 = '0; req_input_var_2 = '0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t1_go_n1", 32'(go), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_go_n2", 32'(go), 32'd1);
    check("t1_opid", 32'(operation_id), 32'd1);
    check("t1_var0", input_var_0, 32'd3);
    @(negedge clk);
    check("t1_go_n3", 32'(go), 32'd0);
    repeat (9) @(negedge clk);
    check("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_ontime", 32'(rsp_valid), 32'd1);
    expect_rsp("t1", 8'd1, 32'd96, 1'b0);
    check("t1_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_go_count", 32'(go_cnt - g0), 32'd1);

    // 2: five back-to-back requests, depth 4, responder slow
    resp_delay = 12;
    for (int i = 1; i <= 5; i++) push_one("t2_push", 8'(8'h10 + i), 32'(i));
    end_push();
    check("t2_full", 32'(req_ready), 32'd0);
    for (int i = 1; i <= 5; i++) expect_rsp("t2_rsp", 8'(8'h10 + i), 32'(i * 32), 1'b0);

    // 3: responder never finishes -> timeout after 16 WAIT cycles
    use_auto = 1'b0; man_fin = 1'b0; man_res = 32'hdead_beef;
    push_one("t3_push", 8'h21, 32'd9);
    end_push();
    n = 0;
    while (go !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t3_go", 32'(go), 32'd1);
    repeat (16) @(negedge clk);
    check("t3_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t3_rsp_ontime", 32'(rsp_valid), 32'd1);
    expect_rsp("t3", 8'h21, 32'd0, 1'b1);
    use_auto = 1'b1; resp_delay = 3;
    push_one("t3b_push", 8'h22, 32'd4);
    end_push();
    expect_rsp("t3b", 8'h22, 32'd128, 1'b0);

    // 4: response held off for 20 cycles
    push_one("t4_push", 8'h30, 32'd2);
    end_push();
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    g0 = go_cnt;
    bad = 1'b0;
    push_one("t4_push_y", 8'h31, 32'd5);
    push_one("t4_push_z", 8'h32, 32'd6);
    end_push();
    for (int i = 0; i < 17; i++) begin
      if (rsp_valid !== 1'b1 || rsp_operation_id !== 8'h30 || rsp_results !== 32'd64 ||
          rsp_timeout !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("t4_stable", 32'(bad), 32'd0);
    check("t4_no_go", 32'(go_cnt - g0), 32'd0);
    check("t4_req_ready", 32'(req_ready), 32'd1);
    expect_rsp("t4x", 8'h30, 32'd64, 1'b0);
    expect_rsp("t4y", 8'h31, 32'd160, 1'b0);
    expect_rsp("t4z", 8'h32, 32'd192, 1'b0);

    // 5: finished already high at launch must fall and rise again
    use_auto = 1'b0; man_fin = 1'b1; man_res = '0;
    repeat (2) @(negedge clk);
    push_one("t5_push", OP_GCD, 32'd12);
    end_push();
    n = 0;
    while (go !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t5_go", 32'(go), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    check("t5_no_early", 32'(bad), 32'd0);
    man_fin = 1'b0;
    repeat (2) @(negedge clk);
    man_res = 32'd7; man_fin = 1'b1;
    expect_rsp("t5", OP_GCD, 32'd7, 1'b0);

    // 6: reset during WAIT with two requests queued
    use_auto = 1'b1; man_fin = 1'b0; resp_delay = 12;
    g0 = go_cnt;
    push_one("t6_push_a", 8'h40, 32'd3);
    push_one("t6_push_b", 8'h41, 32'd4);
    push_one("t6_push_c", 8'h42, 32'd5);
    end_push();
    n = 0;
    while (go_cnt == g0 && n < 50) begin @(negedge clk); n++; end
    check("t6_launched", 32'(go_cnt - g0), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_go", 32'(go), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_opid", 32'(operation_id), 32'd0);
    check("t6_var0", input_var_0, 32'd0);
    check("t6_rsp_res", rsp_results, 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    g0 = go_cnt;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("t6_quiet", 32'(bad), 32'd0);
    check("t6_no_go", 32'(go_cnt - g0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
